rk_crtc_seq: RTL and testbench

RK_CRTC_SEQ -- requirements
Module: rk_crtc_seq

---
 rtl/rk_crtc_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_rk_crtc_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rk_crtc_seq.sv
// rk_crtc_seq: character-row CRT sequencer.
// Fetches one row of character codes from screen memory into a fill buffer
// while the previous row is shown from a display buffer, then swaps the two
// buffers at each row boundary. Emits per-character code, scan line, blanking,
// cursor and reverse-video attributes, one character per cce pulse.
module rk_crtc_seq #(
    parameter int          COLS      = 78,
    parameter int          ROWS      = 30,
    parameter int          LINES     = 10,
    parameter logic [15:0] BASE_ADDR = 16'h76D0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hr_wg75,
    input  logic        vr_wg75,
    input  logic        cce,
    input  logic        cur_we,
    input  logic [6:0]  cur_x,
    input  logic [4:0]  cur_y,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [6:0]  ichar,
    output logic [3:0]  line,
    output logic        vsp,
    output logic        lten,
    output logic        rvv,
    output logic        underrun
);

    localparam int         RW        = 8;
    localparam int         BW        = $clog2(2 * COLS);
    localparam logic [6:0] COLS_W    = 7'(COLS);
    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic [RW-1:0] ROWS_W = RW'(ROWS);
    localparam logic [3:0] LAST_LINE = 4'(LINES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;

    fetch_state_t    fetch_state_reg, fetch_state_next;
    logic [RW-1:0]   fetch_row_reg, fetch_row_next;
    logic [6:0]      fcol_reg, fcol_next;
    logic            disp_sel_reg, disp_sel_next;
    logic            prologue_reg, prologue_next;
    logic [RW-1:0]   row_reg, row_next;
    logic [3:0]      line_reg, line_next;
    logic [6:0]      col_reg, col_next;
    logic            underrun_reg, underrun_next;
    logic            row_blank_reg, row_blank_next;
    logic [4:0]      frame_reg, frame_next;

    logic            hr_prev_reg, vr_prev_reg;
    logic [6:0]      cur_x_reg;
    logic [4:0]      cur_y_reg;

    logic [6:0]      ichar_reg;
    logic [3:0]      line_out_reg;
    logic            vsp_reg, lten_reg, rvv_reg;

    // Both row buffers live in one array: half 0 and half 1, selected by disp_sel.
    logic [7:0]      buf_mem [0:2*COLS-1];
    logic [BW-1:0]   wr_idx, rd_idx;
    logic [6:0]      rd_col;
    logic [7:0]      rd_byte;

    logic            hr_fall, vr_fall, ack_ok, blank_now, cursor_hit;

    assign hr_fall  = hr_prev_reg & ~hr_wg75;
    assign vr_fall  = vr_prev_reg & ~vr_wg75;
    assign ack_ok   = mem_ack && (fetch_state_reg == REQ);

    assign mem_req  = (fetch_state_reg == REQ);
    assign mem_addr = BASE_ADDR + 16'(fetch_row_reg) * 16'(COLS) + 16'(fcol_reg);

    // Fill buffer is always the half not being displayed.
    assign wr_idx   = BW'(fcol_reg) + (disp_sel_reg ? BW'(0) : BW'(COLS));
    assign rd_col   = (col_reg < COLS_W) ? col_reg : 7'd0;
    assign rd_idx   = BW'(rd_col) + (disp_sel_reg ? BW'(COLS) : BW'(0));
    assign rd_byte  = buf_mem[rd_idx];

    assign blank_now  = (col_reg >= COLS_W) || (row_reg >= ROWS_W) || !vr_wg75 || row_blank_reg;
    assign cursor_hit = (row_reg == RW'(cur_y_reg)) && (col_reg == cur_x_reg) &&
                        (line_reg == LAST_LINE) && !frame_reg[4];

    // Next-state logic: fetch FSM, row/line/column counters and buffer swaps.
    always_comb begin
        fetch_state_next = fetch_state_reg;
        fetch_row_next   = fetch_row_reg;
        fcol_next        = fcol_reg;
        disp_sel_next    = disp_sel_reg;
        prologue_next    = prologue_reg;
        row_next         = row_reg;
        line_next        = line_reg;
        col_next         = col_reg;
        underrun_next    = underrun_reg;
        row_blank_next   = row_blank_reg;
        frame_next       = frame_reg;

        if (cce && (col_reg < COLS_W)) begin
            col_next = col_reg + 7'd1;
        end

        if (ack_ok) begin
            fcol_next = fcol_reg + 7'd1;
            if (fcol_reg == LAST_COL) begin
                fetch_state_next = DONE;
            end
        end

        if (vr_fall) begin
            // New frame: restart everything at row 0 and prefetch it.
            row_next         = '0;
            line_next        = 4'd0;
            col_next         = 7'd0;
            fetch_row_next   = '0;
            fcol_next        = 7'd0;
            fetch_state_next = REQ;
            prologue_next    = 1'b1;
            row_blank_next   = 1'b0;
            frame_next       = frame_reg + 5'd1;
        end else if (hr_fall) begin
            col_next = 7'd0;
            if (line_reg == LAST_LINE) begin
                line_next     = 4'd0;
                row_next      = (row_reg < ROWS_W) ? row_reg + RW'(1) : row_reg;
                disp_sel_next = ~disp_sel_reg;
                prologue_next = 1'b0;
                // An incomplete fetch means the new row has no valid data.
                if (fetch_state_reg != DONE) begin
                    underrun_next  = 1'b1;
                    row_blank_next = 1'b1;
                end else begin
                    row_blank_next = 1'b0;
                end
                fcol_next = 7'd0;
                if (({1'b0, row_reg} + 9'd2) < {1'b0, ROWS_W}) begin
                    fetch_row_next   = row_reg + RW'(2);
                    fetch_state_next = REQ;
                end else begin
                    fetch_state_next = IDLE;
                end
            end else begin
                line_next = line_reg + 4'd1;
            end
        end else if (prologue_reg && (fetch_state_reg == DONE)) begin
            // Row 0 is in: show it and start prefetching row 1.
            disp_sel_next    = ~disp_sel_reg;
            prologue_next    = 1'b0;
            fetch_row_next   = RW'(1);
            fcol_next        = 7'd0;
            fetch_state_next = (ROWS > 1) ? REQ : IDLE;
        end
    end

    // State register for FSM, counters and sync edge detectors.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_state_reg <= IDLE;
            fetch_row_reg   <= '0;
            fcol_reg        <= 7'd0;
            disp_sel_reg    <= 1'b0;
            prologue_reg    <= 1'b0;
            row_reg         <= '0;
            line_reg        <= 4'd0;
            col_reg         <= 7'd0;
            underrun_reg    <= 1'b0;
            row_blank_reg   <= 1'b0;
            frame_reg       <= 5'd0;
            hr_prev_reg     <= 1'b1;
            vr_prev_reg     <= 1'b1;
        end else begin
            fetch_state_reg <= fetch_state_next;
            fetch_row_reg   <= fetch_row_next;
            fcol_reg        <= fcol_next;
            disp_sel_reg    <= disp_sel_next;
            prologue_reg    <= prologue_next;
            row_reg         <= row_next;
            line_reg        <= line_next;
            col_reg         <= col_next;
            underrun_reg    <= underrun_next;
            row_blank_reg   <= row_blank_next;
            frame_reg       <= frame_next;
            hr_prev_reg     <= hr_wg75;
            vr_prev_reg     <= vr_wg75;
        end
    end

    // Fill-buffer write on each accepted acknowledge (dropped on reset or frame restart).
    always_ff @(posedge clk) begin
        if (ack_ok && !reset && !vr_fall) begin
            buf_mem[wr_idx] <= mem_data;
        end
    end

    // Cursor position latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x_reg <= 7'd0;
            cur_y_reg <= 5'd0;
        end else if (cur_we) begin
            cur_x_reg <= cur_x;
            cur_y_reg <= cur_y;
        end
    end

    // Per-character output register, advanced only on cce.
    always_ff @(posedge clk) begin
        if (reset) begin
            ichar_reg    <= 7'd0;
            line_out_reg <= 4'd0;
            vsp_reg      <= 1'b1;
            lten_reg     <= 1'b0;
            rvv_reg      <= 1'b0;
        end else if (cce) begin
            vsp_reg      <= blank_now;
            line_out_reg <= line_reg;
            lten_reg     <= cursor_hit;
            if (blank_now) begin
                ichar_reg <= 7'd0;
                rvv_reg   <= 1'b0;
            end else begin
                ichar_reg <= rd_byte[6:0];
                rvv_reg   <= rd_byte[7];
            end
        end
    end

    assign ichar    = ichar_reg;
    assign line     = line_out_reg;
    assign vsp      = vsp_reg;
    assign lten     = lten_reg;
    assign rvv      = rvv_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_rk_crtc_seq.sv
// Directed testbench for rk_crtc_seq: fetch sequencing, character output,
// underrun handling, cursor blink and reset behaviour.
module tb_rk_crtc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        hr_wg75, vr_wg75, cce, cur_we;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [6:0]  ichar;
    logic [3:0]  line;
    logic        vsp, lten, rvv, underrun;

    logic        ack_en;
    logic        ovr_en;
    int          total = 0;
    int          bad   = 0;

    rk_crtc_seq dut (
        .clk(clk), .reset(reset), .hr_wg75(hr_wg75), .vr_wg75(vr_wg75),
        .cce(cce), .cur_we(cur_we), .cur_x(cur_x), .cur_y(cur_y),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .ichar(ichar), .line(line), .vsp(vsp),
        .lten(lten), .rvv(rvv), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Memory model: answers in the request cycle, data is the low address byte
    // unless the override plants 0xC1 at the screen base.
    assign mem_ack  = ack_en & mem_req;
    assign mem_data = (ovr_en && mem_addr == 16'h76D0) ? 8'hC1 : mem_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cce_pulse;
        cce = 1'b1;
        @(posedge clk); #1;
        cce = 1'b0;
    endtask

    task automatic hr_pulse;
        hr_wg75 = 1'b0;
        @(posedge clk); #1;
        hr_wg75 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic vr_pulse;
        vr_wg75 = 1'b0;
        @(posedge clk); #1;
        vr_wg75 = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] b;
        int n;
        logic found;

        reset = 1'b1; hr_wg75 = 1'b1; vr_wg75 = 1'b1; cce = 1'b0;
        cur_we = 1'b0; cur_x = 7'd0; cur_y = 5'd0; ack_en = 1'b0; ovr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ichar", 32'(ichar), 32'h0);
        chk("rst_line", 32'(line), 32'h0);
        chk("rst_vsp", 32'(vsp), 32'h1);
        chk("rst_lten", 32'(lten), 32'h0);
        chk("rst_rvv", 32'(rvv), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h76D0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        $display("txn reset: ichar=%0h line=%0d vsp=%0b addr=%0h", ichar, line, vsp, mem_addr);

        // Row 0 fetch after vr falling edge: 78 sequential addresses
        ack_en = 1'b1;
        vr_wg75 = 1'b0;
        @(posedge clk); #1;
        vr_wg75 = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 78; cyc++) begin
            if (mem_req) begin
                chk("fetch0_addr", 32'(mem_addr), 32'(16'h76D0 + 16'(n)));
                n++;
            end
            @(posedge clk); #1;
        end
        ack_en = 1'b0;
        chk("fetch0_count", 32'(n), 32'd78);
        chk("fetch0_done_req", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        chk("fetch1_req", 32'(mem_req), 32'h1);
        chk("fetch1_addr", 32'(mem_addr), 32'h771E);
        $display("txn fetch row0: acks=%0d next_addr=%0h", n, mem_addr);

        // 78 characters of row 0 line 0
        for (int c = 0; c < 78; c++) begin
            b = 8'(16'h76D0 + 16'(c));
            cce_pulse();
            chk("row0_ichar", 32'(ichar), 32'(b[6:0]));
            chk("row0_rvv", 32'(rvv), 32'(b[7]));
            chk("row0_vsp", 32'(vsp), 32'h0);
        end
        cce_pulse();
        chk("col79_vsp", 32'(vsp), 32'h1);
        chk("col79_ichar", 32'(ichar), 32'h0);
        chk("col79_rvv", 32'(rvv), 32'h0);
        hr_pulse();
        cce_pulse();
        chk("hr_line", 32'(line), 32'h1);
        chk("hr_col0_ichar", 32'(ichar), 32'h50);
        $display("txn row0 line0: 79 cce, then hr -> line=%0d ichar=%0h", line, ichar);

        // Row 1 never acknowledged: underrun at the swap, row 2 fetch issued
        repeat (9) hr_pulse();
        chk("underrun_set", 32'(underrun), 32'h1);
        chk("row2_req", 32'(mem_req), 32'h1);
        chk("row2_addr", 32'(mem_addr), 32'h776C);
        for (int c = 0; c < 3; c++) begin
            cce_pulse();
            chk("row1_vsp", 32'(vsp), 32'h1);
            chk("row1_ichar", 32'(ichar), 32'h0);
        end
        $display("txn underrun: underrun=%0b addr=%0h vsp=%0b", underrun, mem_addr, vsp);

        // Let row 2 complete, move to row 2 line 9, cursor at (5,2)
        ack_en = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(posedge clk); #1;
            if (!mem_req) found = 1'b1;
        end
        chk("row2_fetch_done", 32'(found), 32'h1);
        repeat (10) hr_pulse();
        repeat (9) hr_pulse();
        cur_x = 7'd5; cur_y = 5'd2; cur_we = 1'b1;
        @(posedge clk); #1;
        cur_we = 1'b0;
        repeat (5) cce_pulse();
        chk("cur_col4_lten", 32'(lten), 32'h0);
        cce_pulse();
        chk("cur_lten_on", 32'(lten), 32'h1);
        chk("row2_col5_ichar", 32'(ichar), 32'h71);
        chk("row2_col5_rvv", 32'(rvv), 32'h0);
        chk("row2_line9", 32'(line), 32'h9);
        chk("underrun_sticky", 32'(underrun), 32'h1);
        $display("txn cursor frame1: lten=%0b ichar=%0h line=%0d", lten, ichar, line);

        // Frame counter to 16: cursor hidden at the same position
        repeat (15) vr_pulse();
        repeat (29) hr_pulse();
        repeat (6) cce_pulse();
        chk("cur_lten_off", 32'(lten), 32'h0);
        chk("blink_line9", 32'(line), 32'h9);
        $display("txn cursor frame16: lten=%0b line=%0d", lten, line);

        // 0xC1 at column 0, vsp during vr low, then reset mid-fetch
        ovr_en = 1'b1;
        vr_wg75 = 1'b0;
        @(posedge clk); #1;
        cce_pulse();
        chk("vr_low_vsp", 32'(vsp), 32'h1);
        vr_wg75 = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 300 && !found; cyc++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 16'h771E) found = 1'b1;
        end
        chk("prologue_done", 32'(found), 32'h1);
        hr_pulse();
        cce_pulse();
        chk("c1_ichar", 32'(ichar), 32'h41);
        chk("c1_rvv", 32'(rvv), 32'h1);
        chk("c1_vsp", 32'(vsp), 32'h0);
        $display("txn c1: ichar=%0h rvv=%0b", ichar, rvv);
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_vsp", 32'(vsp), 32'h1);
        chk("midrst_ichar", 32'(ichar), 32'h0);
        chk("midrst_addr", 32'(mem_addr), 32'h76D0);
        chk("midrst_underrun", 32'(underrun), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_req", 32'(mem_req), 32'h0);
        $display("txn reset mid-fetch: mem_req=%0b vsp=%0b", mem_req, vsp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
